// File: rtl/ddr3_ctrl_pkg.sv
// Shared types and defaults for the DDR3 command scheduler: FSM state encoding,
// the command chosen by the idle decision, and its mapping onto command pulses.
package ddr3_ctrl_pkg;

    localparam int TREFI_DEF    = 780;
    localparam int MAX_DEBT_DEF = 8;
    localparam int DEBT_W_DEF   = 4;
    localparam int ROW_W        = 15;
    localparam int COL_W        = 10;
    localparam int BANK_W       = 3;

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_ISSUE_REF = 3'd2,
        S_ISSUE_ACC = 3'd3,
        S_WAIT_ACK  = 3'd4,
        S_WAIT_DONE = 3'd5
    } sched_state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_REF   = 2'd1,
        CMD_READ  = 2'd2,
        CMD_WRITE = 2'd3
    } sched_cmd_t;

    // Pulse vector {REF, ACT, READ, WRITE}; ACT always accompanies READ or WRITE.
    function automatic logic [3:0] cmd_pulses(input sched_cmd_t cmd);
        logic [3:0] p;
        case (cmd)
            CMD_REF:   p = 4'b1000;
            CMD_READ:  p = 4'b0110;
            CMD_WRITE: p = 4'b0101;
            default:   p = 4'b0000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// tREFI interval counter plus saturating count of refreshes still owed.
// A tick and a completed refresh in the same cycle cancel out.
module ddr_refresh_timer
    import ddr3_ctrl_pkg::*;
#(
    parameter int TREFI    = TREFI_DEF,
    parameter int MAX_DEBT = MAX_DEBT_DEF,
    parameter int DEBT_W   = DEBT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              enable,
    input  logic              dec,
    output logic [DEBT_W-1:0] debt,
    output logic              overflow
);

    localparam int CNT_W = (TREFI > 1) ? $clog2(TREFI) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TREFI - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);

    logic [CNT_W-1:0]  cnt_r;
    logic [DEBT_W-1:0] debt_r;
    logic [DEBT_W-1:0] debt_nxt_s;
    logic              overflow_r;
    logic              ovf_set_s;
    logic              tick_s;

    assign tick_s = enable && (cnt_r == CNT_LAST);

    // Interval counter, free-running once enabled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_r <= tick_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Debt update; only a tick that cannot be counted marks an overflow.
    always_comb begin
        debt_nxt_s = debt_r;
        ovf_set_s  = 1'b0;
        case ({tick_s, dec})
            2'b10: begin
                if (debt_r == DEBT_MAX) begin
                    ovf_set_s = 1'b1;
                end else begin
                    debt_nxt_s = debt_r + DEBT_W'(1);
                end
            end
            2'b01: begin
                if (debt_r != {DEBT_W{1'b0}}) begin
                    debt_nxt_s = debt_r - DEBT_W'(1);
                end else begin
                    debt_nxt_s = debt_r;
                end
            end
            default: debt_nxt_s = debt_r;
        endcase
    end

    // Debt and sticky overflow registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            debt_r     <= {DEBT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            debt_r     <= debt_nxt_s;
            overflow_r <= overflow_r | ovf_set_s;
        end
    end

    assign debt     = debt_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Chooses the next DDR3 command sequence (refresh or host access), issues it as
// one-cycle pulses and waits for the command FSM to finish a full pass.
module ddr_cmd_scheduler
    import ddr3_ctrl_pkg::*;
#(
    parameter int TREFI    = TREFI_DEF,
    parameter int MAX_DEBT = MAX_DEBT_DEF,
    parameter int DEBT_W   = DEBT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              init_done,
    input  logic              cmd_idle,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    input  logic [BANK_W-1:0] req_bank,
    output logic              REF,
    output logic              ACT,
    output logic              READ,
    output logic              WRITE,
    output logic [ROW_W-1:0]  Addr_Row,
    output logic [COL_W-1:0]  Addr_Column,
    output logic [BANK_W-1:0] BA_out,
    output logic [DEBT_W-1:0] ref_debt,
    output logic              ref_overflow
);

    localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);

    sched_state_t      state_r;
    sched_state_t      state_nxt_s;
    sched_cmd_t        cmd_nxt_s;
    logic              req_ready_s;
    logic              latch_s;
    logic              ref_r;
    logic              act_r;
    logic              read_r;
    logic              write_r;
    logic [ROW_W-1:0]  row_r;
    logic [COL_W-1:0]  col_r;
    logic [BANK_W-1:0] bank_r;
    logic [DEBT_W-1:0] debt_s;
    logic              overflow_s;
    logic              timer_en_s;
    logic              ref_done_s;

    assign timer_en_s = (state_r != S_INIT);
    assign ref_done_s = (state_r == S_ISSUE_REF);

    ddr_refresh_timer #(
        .TREFI    (TREFI),
        .MAX_DEBT (MAX_DEBT),
        .DEBT_W   (DEBT_W)
    ) u_refresh_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .enable   (timer_en_s),
        .dec      (ref_done_s),
        .debt     (debt_s),
        .overflow (overflow_s)
    );

    // Next-state and idle-decision logic; a saturated debt outranks the host.
    always_comb begin
        state_nxt_s = state_r;
        cmd_nxt_s   = CMD_NONE;
        req_ready_s = 1'b0;
        latch_s     = 1'b0;
        case (state_r)
            S_INIT: begin
                if (init_done) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_INIT;
                end
            end
            S_IDLE: begin
                if (!cmd_idle) begin
                    state_nxt_s = S_IDLE;
                end else if (debt_s == DEBT_MAX) begin
                    state_nxt_s = S_ISSUE_REF;
                    cmd_nxt_s   = CMD_REF;
                end else if (req_valid) begin
                    req_ready_s = 1'b1;
                    latch_s     = 1'b1;
                    state_nxt_s = S_ISSUE_ACC;
                    cmd_nxt_s   = req_write ? CMD_WRITE : CMD_READ;
                end else if (debt_s != {DEBT_W{1'b0}}) begin
                    state_nxt_s = S_ISSUE_REF;
                    cmd_nxt_s   = CMD_REF;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE_REF: state_nxt_s = S_WAIT_ACK;
            S_ISSUE_ACC: state_nxt_s = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!cmd_idle) begin
                    state_nxt_s = S_WAIT_DONE;
                end else begin
                    state_nxt_s = S_WAIT_ACK;
                end
            end
            S_WAIT_DONE: begin
                if (cmd_idle) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_WAIT_DONE;
                end
            end
            default: state_nxt_s = S_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= S_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command pulses are high exactly during the S_ISSUE_* cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            {ref_r, act_r, read_r, write_r} <= 4'b0000;
        end else begin
            {ref_r, act_r, read_r, write_r} <= cmd_pulses(cmd_nxt_s);
        end
    end

    // Address latches hold from acceptance until the next accepted request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_r  <= {ROW_W{1'b0}};
            col_r  <= {COL_W{1'b0}};
            bank_r <= {BANK_W{1'b0}};
        end else if (latch_s) begin
            row_r  <= req_row;
            col_r  <= req_col;
            bank_r <= req_bank;
        end else begin
            row_r  <= row_r;
            col_r  <= col_r;
            bank_r <= bank_r;
        end
    end

    assign req_ready    = req_ready_s;
    assign REF          = ref_r;
    assign ACT          = act_r;
    assign READ         = read_r;
    assign WRITE        = write_r;
    assign Addr_Row     = row_r;
    assign Addr_Column  = col_r;
    assign BA_out       = bank_r;
    assign ref_debt     = debt_s;
    assign ref_overflow = overflow_s;

endmodule
